uart_cmd_ctrl: RTL and testbench

Sequencer sitting between the UART receiver and the command decoder. Consumes bytes from the receiver's rdy/rx_data/clr_rdy handshake. Assembles 3-byte frames: opcode, data high byte, data low byte. Presents each frame as one command word with a ready/clear handshake, and discards partial frames after an inter-byte timeout.

---
 rtl/uart_cmd_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles opcode/data-high/data-low byte frames from the UART
// receiver into one command word, handed to the decoder via cmd_rdy/clr_cmd_rdy.
// Partial frames are dropped (to_err pulse) when the inter-byte gap is too long.
// Optional build macro UART_CMD_CKSUM_EN: adds a fourth checksum byte; a frame
// is published only if the modulo-256 sum of all four bytes is zero.
module uart_cmd_ctrl #(
    parameter int TIMEOUT_CYC = 78120,
    parameter int FRAME_BYTES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rdy,
    input  logic        clr_cmd_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        to_err
);

    localparam int CNT_W = 17;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

    // Frame length is fixed by the decoder; refuse to elaborate anything else.
    generate
        if (FRAME_BYTES != 3) begin : g_frame_bytes_check
            $error("uart_cmd_ctrl supports FRAME_BYTES == 3 only");
        end
    endgenerate

`ifdef UART_CMD_CKSUM_EN
    typedef enum logic [2:0] {IDLE, HIGH, LOW, CKSUM, READY} state_t;
`else
    typedef enum logic [2:0] {IDLE, HIGH, LOW, READY} state_t;
`endif

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [7:0]         cmd_reg, cmd_next;
    logic [15:0]        data_reg, data_next;
    logic               cmd_rdy_reg, cmd_rdy_next;
    logic               to_err_reg, to_err_next;
    logic               accept;
    logic               waiting;

`ifdef UART_CMD_CKSUM_EN
    // Bytes of the frame in flight; cmd/data are only updated once the
    // checksum has been verified.
    logic [7:0]         b1_reg, b1_next;
    logic [7:0]         b2_reg, b2_next;
    logic [7:0]         b3_reg, b3_next;
    logic [7:0]         sum;

    assign sum = b1_reg + b2_reg + b3_reg + rx_data;
    assign waiting = (state_reg == HIGH) || (state_reg == LOW) || (state_reg == CKSUM);
`else
    assign waiting = (state_reg == HIGH) || (state_reg == LOW);
`endif

    // A byte is taken whenever one is offered and no frame is being held.
    assign accept  = rdy && (state_reg != READY);
    assign clr_rdy = accept;

    assign cmd_rdy = cmd_rdy_reg;
    assign cmd     = cmd_reg;
    assign data    = data_reg;
    assign to_err  = to_err_reg;

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            cmd_reg     <= 8'h00;
            data_reg    <= 16'h0000;
            cmd_rdy_reg <= 1'b0;
            to_err_reg  <= 1'b0;
`ifdef UART_CMD_CKSUM_EN
            b1_reg      <= 8'h00;
            b2_reg      <= 8'h00;
            b3_reg      <= 8'h00;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            cmd_reg     <= cmd_next;
            data_reg    <= data_next;
            cmd_rdy_reg <= cmd_rdy_next;
            to_err_reg  <= to_err_next;
`ifdef UART_CMD_CKSUM_EN
            b1_reg      <= b1_next;
            b2_reg      <= b2_next;
            b3_reg      <= b3_next;
`endif
        end
    end

    // Next-state logic: byte sequencing, inter-byte timeout and decoder handshake.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        cmd_next     = cmd_reg;
        data_next    = data_reg;
        cmd_rdy_next = cmd_rdy_reg;
        to_err_next  = 1'b0;
`ifdef UART_CMD_CKSUM_EN
        b1_next      = b1_reg;
        b2_next      = b2_reg;
        b3_next      = b3_reg;
`endif

        // Mid-frame idle cycle: count, or abandon the frame at terminal count.
        // An accept in the same cycle is handled below and takes precedence.
        if (waiting && !accept) begin
            if (cnt_reg == TERM) begin
                state_next  = IDLE;
                to_err_next = 1'b1;
                cnt_next    = '0;
            end else begin
                cnt_next = cnt_reg + 17'd1;
            end
        end

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (accept) begin
`ifdef UART_CMD_CKSUM_EN
                    b1_next  = rx_data;
`else
                    cmd_next = rx_data;
`endif
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (accept) begin
`ifdef UART_CMD_CKSUM_EN
                    b2_next = rx_data;
`else
                    data_next[15:8] = rx_data;
`endif
                    state_next = LOW;
                    cnt_next   = '0;
                end
            end
            LOW: begin
                if (accept) begin
`ifdef UART_CMD_CKSUM_EN
                    b3_next    = rx_data;
                    state_next = CKSUM;
`else
                    data_next[7:0] = rx_data;
                    cmd_rdy_next   = 1'b1;
                    state_next     = READY;
`endif
                    cnt_next = '0;
                end
            end
`ifdef UART_CMD_CKSUM_EN
            CKSUM: begin
                if (accept) begin
                    cnt_next = '0;
                    if (sum == 8'h00) begin
                        cmd_next     = b1_reg;
                        data_next    = {b2_reg, b3_reg};
                        cmd_rdy_next = 1'b1;
                        state_next   = READY;
                    end else begin
                        to_err_next = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
`endif
            READY: begin
                cnt_next = '0;
                if (clr_cmd_rdy) begin
                    cmd_rdy_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames followed by a random byte stream,
// checked against a byte-stream reference model of the framing rules.
module tb_uart_cmd_ctrl;

    localparam int T = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_cmd_rdy = 1'b0;
    logic        clr_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        to_err;

    uart_cmd_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .rx_data     (rx_data),
        .clr_rdy     (clr_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .to_err      (to_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Event monitors: edge count, clr_rdy cycles, to_err cycles, held-word stability.
    int          cyc = 0;
    int          acc_cnt = 0;
    int          err_cnt = 0;
    int          stab_bad = 0;
    logic        prev_rdy = 1'b0;
    logic [23:0] prev_word = 24'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clr_rdy) acc_cnt <= acc_cnt + 1;
        if (to_err)  err_cnt <= err_cnt + 1;
        if (cmd_rdy && prev_rdy && ({cmd, data} != prev_word)) stab_bad <= stab_bad + 1;
        prev_rdy  <= cmd_rdy;
        prev_word <= {cmd, data};
    end

    // Reference model: frame in flight as a byte queue plus last published word.
    logic [7:0]  m_q[$];
    logic [7:0]  m_cmd = 8'h00;
    logic [15:0] m_data = 16'h0000;
    logic        m_ready = 1'b0;
    int          m_acc = 0;
    int          m_err = 0;
    int          last_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] b, input int c);
        // More than T clocks since the previous byte: the frame was abandoned.
        if (m_q.size() > 0 && (c - last_acc) > T) begin
            m_q.delete();
            m_err++;
        end
        m_acc++;
        last_acc = c;
        m_q.push_back(b);
`ifdef UART_CMD_CKSUM_EN
        if (m_q.size() == 4) begin
            if (8'(m_q[0] + m_q[1] + m_q[2] + m_q[3]) == 8'h00) begin
                m_cmd   = m_q[0];
                m_data  = {m_q[1], m_q[2]};
                m_ready = 1'b1;
            end else begin
                m_err++;
            end
            m_q.delete();
        end
`else
        if (m_q.size() == 1) m_cmd = b;
        if (m_q.size() == 2) m_data[15:8] = b;
        if (m_q.size() == 3) begin
            m_data[7:0] = b;
            m_ready = 1'b1;
            m_q.delete();
        end
`endif
    endtask

    task automatic model_flush(input int c);
        if (m_q.size() > 0 && (c - last_acc) > T) begin
            m_q.delete();
            m_err++;
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cmd   = 8'h00;
        m_data  = 16'h0000;
        m_ready = 1'b0;
    endtask

    // Receiver side: offer a byte and wait (bounded) for the edge that takes it.
    task automatic present(input logic [7:0] b);
        rdy     = 1'b1;
        rx_data = b;
    endtask

    task automatic wait_accept();
        bit got;
        got = 1'b0;
        for (int w = 0; w < 4 * T && !got; w++) begin
            #1;
            got = clr_rdy;
            @(posedge clk);
        end
        #1;
        rdy = 1'b0;
        if (got) model_accept(rx_data, cyc);
        else check("accept_wait", 32'd0, 32'd1);
    endtask

    // Byte accepted k edges after the previous accept (caller sits 1ns after an edge).
    task automatic send(input logic [7:0] b, input int k);
        repeat (k - 1) @(posedge clk);
        #1;
        present(b);
        wait_accept();
    endtask

    task automatic ack();
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        m_ready = 1'b0;
        check("ack_drop", {31'd0, cmd_rdy}, 32'd0);
    endtask

    task automatic check_outputs(input string tag);
        @(negedge clk);
        @(posedge clk);
        #1;
        model_flush(cyc);
        check({tag, "_cmd_rdy"}, {31'd0, cmd_rdy}, {31'd0, m_ready});
        check({tag, "_cmd"}, {24'd0, cmd}, {24'd0, m_cmd});
        check({tag, "_data"}, {16'd0, data}, {16'd0, m_data});
        check({tag, "_errs"}, err_cnt, m_err);
        check({tag, "_accepts"}, acc_cnt, m_acc);
    endtask

    initial begin
        int a0;
        int k;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("rst_cmd", {24'd0, cmd}, 32'h00);
        check("rst_data", {16'd0, data}, 32'h0000);
        check("rst_to_err", {31'd0, to_err}, 32'd0);
        check("rst_clr_rdy", {31'd0, clr_rdy}, 32'd0);
        rst_n = 1'b1;

`ifndef UART_CMD_CKSUM_EN
        // Back-to-back frame.
        a0 = acc_cnt;
        send(8'hA5, 1);
        send(8'h12, 1);
        send(8'h34, 1);
        check("t1_latency", {31'd0, cmd_rdy}, 32'd1);
        check_outputs("t1");
        check("t1_clr_pulses", acc_cnt - a0, 32'd3);
        check("t1_word", {8'd0, cmd, data}, 32'h00A51234);

        // Backpressure while a frame is held, then release.
        present(8'h01);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_blocked", {31'd0, clr_rdy}, 32'd0);
            @(posedge clk);
        end
        #1;
        check("t2_hold", {8'd0, cmd, data}, 32'h00A51234);
        ack();
        a0 = cyc;
        wait_accept();
        check("t2_accept_gap", cyc - a0, 32'd1);
        send(8'h02, 1);
        send(8'h03, 1);
        check_outputs("t2");
        ack();

        // Partial frame abandoned after T idle clocks.
        send(8'h55, 1);
        send(8'h66, 1);
        repeat (T - 1) @(posedge clk);
        #1;
        check("t3_no_err_early", {31'd0, to_err}, 32'd0);
        @(posedge clk);
        #1;
        check("t3_err_pulse", {31'd0, to_err}, 32'd1);
        @(posedge clk);
        #1;
        check("t3_err_end", {31'd0, to_err}, 32'd0);
        check("t3_kept_cmd", {24'd0, cmd}, 32'h55);
        check_outputs("t3a");
        send(8'h0F, 1);
        send(8'hBE, 1);
        send(8'hEF, 1);
        check_outputs("t3b");
        check("t3_word", {8'd0, cmd, data}, 32'h000FBEEF);
        ack();

        // Bytes arriving exactly at terminal count are still taken.
        a0 = err_cnt;
        send(8'h11, 1);
        send(8'h22, T);
        send(8'h33, T);
        check_outputs("t4");
        check("t4_no_err", err_cnt - a0, 32'd0);
        ack();

        // Reset in the middle of a frame.
        send(8'h77, 1);
        send(8'h88, 1);
        rst_n = 1'b0;
        #2;
        model_reset();
        check("t5_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("t5_rst_word", {8'd0, cmd, data}, 32'h0);
        check("t5_rst_to_err", {31'd0, to_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h10, 1);
        send(8'h00, 1);
        send(8'hFF, 1);
        check_outputs("t5");
        check("t5_data", {16'd0, data}, 32'h00FF);
        ack();
`else
        // Good then bad checksum.
        send(8'h01, 1);
        send(8'h02, 1);
        send(8'h03, 1);
        send(8'hFA, 1);
        check_outputs("t6a");
        check("t6_word", {8'd0, cmd, data}, 32'h00010203);
        ack();
        a0 = err_cnt;
        send(8'h01, 1);
        send(8'h02, 1);
        send(8'h03, 1);
        send(8'hFB, 1);
        check_outputs("t6b");
        check("t6_err", err_cnt - a0, 32'd1);
        check("t6_word_kept", {8'd0, cmd, data}, 32'h00010203);
`endif

        // Random byte stream with mostly in-time gaps and occasional timeouts.
        for (int i = 0; i < 120; i++) begin
            k = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, T)) : int'($urandom_range(T + 1, T + 8));
            b = 8'($urandom);
            send(b, k);
            if (m_ready) begin
                check_outputs("rnd");
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                ack();
            end
        end

        repeat (T + 2) @(posedge clk);
        #1;
        check_outputs("final");
        check("stability", stab_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
